// File: rtl/uart_rx_pkg.sv
// Shared types for the parametrised UART receiver. These are the FSM states, the per-entry
// status flags, the frame configuration that is latched at start-bit confirm, and the data-bits clamp.
package uart_rx_pkg;

    localparam int MIN_DATA_BITS = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_e;

    // Status half of a FIFO entry. The data half is sized by DATA_W, so the top module builds the full entry.
    typedef struct packed {
        logic perr;
        logic ferr;
        logic brk;
    } rx_flags_t;

    typedef struct packed {
        logic [3:0] bits;
        logic       parity_en;
        logic       parity_odd;
        logic       stop2;
    } rx_cfg_t;

    function automatic logic [3:0] clamp_bits(input logic [3:0] bits, input int max_bits);
        if (int'(bits) < MIN_DATA_BITS || int'(bits) > max_bits) begin
            return 4'(max_bits);
        end
        return bits;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO. The head word is visible on rd_data_o whenever
// the FIFO is not empty. A write into a full FIFO succeeds only if a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         rd_en_i,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_fire, rd_fire;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (level_o == LVL_W'(DEPTH));

    assign rd_fire = rd_en_i && !empty_o;
    assign wr_fire = wr_en_i && (!full_o || rd_en_i);

    // Gate the head word so that an empty FIFO presents zeros and not stale contents.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array has no reset. The pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver. It has a synchroniser with a 2-of-3 vote front end, a frame FSM
// with parity, stop and break checks, and an integrated FWFT RX FIFO that carries per-entry error flags.
module uart_rx_param
    import uart_rx_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              baud_en,
    input  logic                              rx,
    input  logic [3:0]                        cfg_bits,
    input  logic                              cfg_parity_en,
    input  logic                              cfg_parity_odd,
    input  logic                              cfg_stop2,
    input  logic                              rd_en,
    input  logic                              clr_overflow,
    output logic [DATA_W-1:0]                 rd_data,
    output logic                              rd_parity_err,
    output logic                              rd_frame_err,
    output logic                              rd_break,
    output logic                              rx_valid,
    output logic                              fifo_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overflow
);

    localparam int CNT_W = $clog2(OVERSAMPLE);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        rx_flags_t         flags;
    } rx_entry_t;

    localparam int ENTRY_W = $bits(rx_entry_t);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             vote_q;
    logic                   rx_s, bit_v;

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              zero_q, zero_d;
    rx_cfg_t           cfg_q, cfg_d;
    logic              overflow_q, overflow_d;

    logic              cnt_last, cnt_half;
    logic              push, drop, fifo_empty;
    rx_entry_t         push_entry, head;

    // Both the synchroniser and the vote register preset to idle-high, so reset can never look like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            vote_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
            if (baud_en) vote_q <= {vote_q[1:0], rx_s};
        end
    end

    assign rx_s  = sync_q[SYNC_STAGES-1];
    assign bit_v = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) | (vote_q[1] & vote_q[2]);

    assign cnt_last = (cnt_q == CNT_W'(OVERSAMPLE - 1));
    assign cnt_half = (cnt_q == CNT_W'(OVERSAMPLE / 2 - 1));

    // The entry is built from the bit being sampled now, which is the last stop bit, when push is high.
    assign push_entry = '{data:  shift_q,
                          flags: '{perr: perr_q,
                                   ferr: ferr_q | ~bit_v,
                                   brk:  zero_q & ~bit_v}};

    // NOTE: every variable gets its default before the case, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        zero_d     = zero_q;
        cfg_d      = cfg_q;
        push       = 1'b0;

        if (baud_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!bit_v) begin
                        state_d = ST_START;
                        cnt_d   = '0;
                    end
                end
                ST_START: begin
                    if (cnt_half) begin
                        if (!bit_v) begin
                            state_d          = ST_DATA;
                            cnt_d            = '0;
                            bit_cnt_d        = '0;
                            stop_cnt_d       = 1'b0;
                            shift_d          = '0;
                            par_d            = 1'b0;
                            perr_d           = 1'b0;
                            ferr_d           = 1'b0;
                            zero_d           = 1'b1;
                            cfg_d.bits       = clamp_bits(cfg_bits, DATA_W);
                            cfg_d.parity_en  = cfg_parity_en;
                            cfg_d.parity_odd = cfg_parity_odd;
                            cfg_d.stop2      = cfg_stop2;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_last) begin
                        cnt_d = '0;
                        for (int i = 0; i < DATA_W; i++) begin
                            if (int'(bit_cnt_q) == i) shift_d[i] = bit_v;
                        end
                        par_d     = par_q ^ bit_v;
                        zero_d    = zero_q & ~bit_v;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == cfg_q.bits - 4'd1) begin
                            state_d = cfg_q.parity_en ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (cnt_last) begin
                        cnt_d   = '0;
                        perr_d  = bit_v ^ par_q ^ cfg_q.parity_odd;
                        zero_d  = zero_q & ~bit_v;
                        state_d = ST_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_last) begin
                        cnt_d  = '0;
                        ferr_d = ferr_q | ~bit_v;
                        zero_d = zero_q & ~bit_v;
                        if (cfg_q.stop2 && !stop_cnt_q) begin
                            stop_cnt_d = 1'b1;
                        end else begin
                            push    = 1'b1;
                            state_d = (zero_q & ~bit_v) ? ST_BRK_WAIT : ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_BRK_WAIT: begin
                    if (bit_v) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A drop happens only when the FIFO is full and nothing leaves it in the same cycle. If set and clear coincide, set wins.
    assign drop = push && fifo_full && !rd_en;

    always_comb begin
        overflow_d = overflow_q;
        if (clr_overflow) overflow_d = 1'b0;
        if (drop)         overflow_d = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b0;
            cfg_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            zero_q     <= zero_d;
            cfg_q      <= cfg_d;
            overflow_q <= overflow_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (push),
        .wr_data_i (push_entry),
        .rd_en_i   (rd_en),
        .rd_data_o (head),
        .level_o   (fifo_level),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign rd_data       = head.data;
    assign rd_parity_err = head.flags.perr;
    assign rd_frame_err  = head.flags.ferr;
    assign rd_break      = head.flags.brk;
    assign rx_valid      = !fifo_empty;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed and randomised frames for uart_rx_param. The frame model computes the expected entries,
// and a bounded queue stands in for the RX FIFO.
module tb_uart_rx_param;

    localparam int DATA_W      = 8;
    localparam int FIFO_DEPTH  = 16;
    localparam int OVERSAMPLE  = 16;
    localparam int SYNC_STAGES = 2;
    localparam int BAUD_DIV    = 4;
    localparam int BIT_CLKS    = OVERSAMPLE * BAUD_DIV;

    logic              clk, reset, baud_en, rx;
    logic [3:0]        cfg_bits;
    logic              cfg_parity_en, cfg_parity_odd, cfg_stop2;
    logic              rd_en, clr_overflow;
    logic [DATA_W-1:0] rd_data;
    logic              rd_parity_err, rd_frame_err, rd_break;
    logic              rx_valid, fifo_full, overflow;
    logic [4:0]        fifo_level;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    exp_t exp_q[$];
    logic model_ovf;
    int   checks;
    int   errors;

    uart_rx_param #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .OVERSAMPLE  (OVERSAMPLE),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .baud_en        (baud_en),
        .rx             (rx),
        .cfg_bits       (cfg_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .rd_en          (rd_en),
        .clr_overflow   (clr_overflow),
        .rd_data        (rd_data),
        .rd_parity_err  (rd_parity_err),
        .rd_frame_err   (rd_frame_err),
        .rd_break       (rd_break),
        .rx_valid       (rx_valid),
        .fifo_full      (fifo_full),
        .fifo_level     (fifo_level),
        .overflow       (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        baud_en = 1'b0;
        forever begin
            repeat (BAUD_DIV - 1) @(negedge clk);
            baud_en = 1'b1;
            @(negedge clk);
            baud_en = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic model_push(input exp_t e);
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(e);
        else model_ovf = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        model_ovf = 1'b0;
    endtask

    // Builds the serial frame from its configuration and queues the entry the receiver should produce.
    task automatic send_frame(input int cb, input logic pen, input logic podd, input logic st2,
                              input logic [7:0] data, input logic flip, input logic [1:0] bad,
                              input bit scramble);
        int         eff;
        int         nstop;
        logic [7:0] dm;
        logic       pbit;
        exp_t       e;
        eff   = (cb < 5 || cb > DATA_W) ? DATA_W : cb;
        dm    = data & 8'((1 << eff) - 1);
        pbit  = (^dm) ^ podd ^ flip;
        nstop = st2 ? 2 : 1;
        cfg_bits       = 4'(cb);
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_stop2      = st2;
        drive(1'b0, BIT_CLKS);
        if (scramble) begin
            cfg_bits       = 4'($urandom_range(0, 15));
            cfg_parity_en  = 1'($urandom);
            cfg_parity_odd = 1'($urandom);
            cfg_stop2      = 1'($urandom);
        end
        for (int i = 0; i < eff; i++) drive(dm[i], BIT_CLKS);
        if (pen) drive(pbit, BIT_CLKS);
        for (int s = 0; s < nstop; s++) begin
            if (bad[s]) begin
                if (s == nstop - 1) begin
                    drive(1'b0, BIT_CLKS * 7 / 8);
                    drive(1'b1, BIT_CLKS / 8);
                end else begin
                    drive(1'b0, BIT_CLKS);
                end
            end else begin
                drive(1'b1, BIT_CLKS);
            end
        end
        drive(1'b1, 2 * BIT_CLKS);
        e.data = dm;
        e.perr = pen & flip;
        e.ferr = st2 ? (bad != 2'b00) : bad[0];
        e.brk  = (dm == 8'h00) && (!pen || !pbit) && (st2 ? (bad == 2'b11) : bad[0]);
        model_push(e);
    endtask

    task automatic check_head(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, ".valid"}, rx_valid, 0);
        end else begin
            check({tag, ".valid"}, rx_valid, 1);
            check({tag, ".data"},  rd_data, exp_q[0].data);
            check({tag, ".perr"},  rd_parity_err, exp_q[0].perr);
            check({tag, ".ferr"},  rd_frame_err, exp_q[0].ferr);
            check({tag, ".brk"},   rd_break, exp_q[0].brk);
        end
    endtask

    task automatic pop_check(input string tag);
        check_head(tag);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (exp_q.size() > 0) exp_q.delete(0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".valid"}, rx_valid, 0);
        check({tag, ".data"},  rd_data, 0);
        check({tag, ".flags"}, {rd_parity_err, rd_frame_err, rd_break}, 0);
        check({tag, ".level"}, fifo_level, 0);
        check({tag, ".full"},  fifo_full, 0);
        check({tag, ".ovf"},   overflow, 0);
    endtask

    initial begin
        exp_t       brk_e;
        logic [7:0] v;
        checks         = 0;
        errors         = 0;
        rx             = 1'b1;
        rd_en          = 1'b0;
        clr_overflow   = 1'b0;
        reset          = 1'b0;
        cfg_bits       = 4'd8;
        cfg_parity_en  = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_stop2      = 1'b0;
        model_ovf      = 1'b0;
        @(negedge clk);
        do_reset();
        check_idle_outputs("rst");

        // 8N1 0xA5
        send_frame(8, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 2'b00, 1'b0);
        check("a5.level", fifo_level, exp_q.size());
        pop_check("a5");
        check("a5.level_after", fifo_level, 0);

        // 7E1 with flipped parity, then 8N2 with a low second stop bit
        send_frame(7, 1'b1, 1'b0, 1'b0, 8'h41, 1'b1, 2'b00, 1'b0);
        pop_check("7e1_flip");
        send_frame(8, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 2'b10, 1'b0);
        pop_check("8n2_ferr");

        // Start glitch of 4 baud ticks must be rejected
        cfg_bits = 4'd8; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
        drive(1'b0, 4 * BAUD_DIV);
        drive(1'b1, 2 * BIT_CLKS);
        check("glitch.level", fifo_level, 0);
        check("glitch.valid", rx_valid, 0);

        // Break: line low for 12 bit times, then a clean 0x55
        drive(1'b0, 12 * BIT_CLKS);
        drive(1'b1, 2 * BIT_CLKS);
        brk_e.data = 8'h00; brk_e.perr = 1'b0; brk_e.ferr = 1'b1; brk_e.brk = 1'b1;
        model_push(brk_e);
        check("brk.level", fifo_level, exp_q.size());
        send_frame(8, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 2'b00, 1'b0);
        check("brk55.level", fifo_level, exp_q.size());
        pop_check("brk");
        pop_check("after_brk");

        // Random frames. The config is scrambled mid-frame to prove it is latched at start confirm.
        for (int i = 0; i < 12; i++) begin
            logic pen;
            pen = 1'($urandom);
            send_frame($urandom_range(3, 10), pen, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
                       pen & 1'($urandom),
                       ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00, 1'b1);
            if (i % 2 == 1) begin
                check("rnd.level", fifo_level, exp_q.size());
                pop_check("rnd0");
                pop_check("rnd1");
            end
        end

        // Overflow: 17 frames unread into a 16-deep FIFO
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            send_frame(8, 1'b0, 1'b0, 1'b0, 8'($urandom), 1'b0, 2'b00, 1'b0);
        end
        check("ovf.level", fifo_level, exp_q.size());
        check("ovf.full", fifo_full, 1);
        check("ovf.flag", overflow, model_ovf);
        for (int i = 0; i < FIFO_DEPTH; i++) pop_check("ovf.pop");
        check_head("ovf.empty");
        check("ovf.sticky", overflow, model_ovf);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        model_ovf = 1'b0;
        check("ovf.cleared", overflow, model_ovf);

        // Reset during data bit 3 with one entry already queued
        send_frame(8, 1'b0, 1'b0, 1'b0, 8'h96, 1'b0, 2'b00, 1'b0);
        check("pre_rst.level", fifo_level, exp_q.size());
        v = 8'h3C;
        drive(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) drive(v[i], BIT_CLKS);
        drive(v[3], BIT_CLKS / 2);
        do_reset();
        drive(1'b1, 2 * BIT_CLKS);
        check_idle_outputs("midrst");
        send_frame(8, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 2'b00, 1'b0);
        check("post_rst.level", fifo_level, exp_q.size());
        pop_check("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
